// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC, imem handshake, instruction register and decoded field outputs.
// Define IFETCH_TIMEOUT_EN to halt with a sticky fault when a fetch waits too long.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  pcsrc,
   input  logic        halt,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [15:0] imm16,
   output logic        exec_stb,
   output logic        halted,
   output logic        fault
);

   typedef enum logic [1:0] {FETCH, EXEC, HALTED} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] next_pc;

   if (TIMEOUT_CYCLES < 1 || RESET_PC[1:0] != 2'b00) begin : g_param_chk
      $error("pc_fetch_unit: TIMEOUT_CYCLES must be >= 1 and RESET_PC word-aligned");
   end

`ifdef IFETCH_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fault_q, fault_d;
`endif

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      case (pcsrc)
         2'd1:    next_pc = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
         2'd2:    next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
         default: next_pc = pc_plus4;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
`ifdef IFETCH_TIMEOUT_EN
      cnt_d   = cnt_q;
      fault_d = fault_q;
`endif
      case (state_q)
         FETCH: begin
            if (imem_ready) begin
               instr_d = imem_rdata;
               state_d = EXEC;
`ifdef IFETCH_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
`ifdef IFETCH_TIMEOUT_EN
            // The edge that would complete the TIMEOUT_CYCLES-th wait raises the fault.
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               fault_d = 1'b1;
               state_d = HALTED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
         end
         EXEC: begin
            if (halt) begin
               state_d = HALTED;
            end else begin
               pc_d    = next_pc;
               state_d = FETCH;
            end
         end
         HALTED:  state_d = HALTED;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         instr_q <= '0;
`ifdef IFETCH_TIMEOUT_EN
         cnt_q   <= '0;
         fault_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
`ifdef IFETCH_TIMEOUT_EN
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
`endif
      end
   end

`ifdef IFETCH_TIMEOUT_EN
   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

   assign imem_req  = (state_q == FETCH) && !rst;
   assign imem_addr = {pc_q[31:2], 2'b00};
   assign pc        = pc_q;
   assign instr     = instr_q;
   assign op        = instr_q[31:26];
   assign rs        = instr_q[25:21];
   assign rt        = instr_q[20:16];
   assign rd        = instr_q[15:11];
   assign shamt     = instr_q[10:6];
   assign funct     = instr_q[5:0];
   assign imm16     = instr_q[15:0];
   assign exec_stb  = (state_q == EXEC);
   assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: driver pushes expected instructions, monitor checks each exec_stb.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  pcsrc;
   logic        halt;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] pc, pc_plus4, instr;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm16;
   logic        exec_stb, halted, fault;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] word;
      int          gap;   // expected cycles since previous exec_stb, 0 = don't care
   } exp_t;
   exp_t sb[$];

   pc_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(15)) dut (
      .clk(clk), .rst(rst), .pcsrc(pcsrc), .halt(halt),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_ready(imem_ready), .pc(pc), .pc_plus4(pc_plus4), .instr(instr),
      .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
      .imm16(imm16), .exec_stb(exec_stb), .halted(halted), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every exec_stb must match the oldest pushed expectation.
   initial begin
      int   cyc  = 0;
      int   last = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         if (exec_stb === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_exec", 32'(exec_stb), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("exec_pc", pc, e.addr);
               chk("exec_pc_plus4", pc_plus4, e.addr + 32'd4);
               chk("exec_instr", instr, e.word);
               chk("exec_op", 32'(op), 32'(e.word[31:26]));
               chk("exec_rs", 32'(rs), 32'(e.word[25:21]));
               chk("exec_rt", 32'(rt), 32'(e.word[20:16]));
               chk("exec_rd", 32'(rd), 32'(e.word[15:11]));
               chk("exec_shamt", 32'(shamt), 32'(e.word[10:6]));
               chk("exec_funct", 32'(funct), 32'(e.word[5:0]));
               chk("exec_imm16", 32'(imm16), 32'(e.word[15:0]));
               chk("exec_req_low", 32'(imem_req), 32'd0);
               if (e.gap != 0) chk("exec_gap", 32'(cyc - last), 32'(e.gap));
            end
            last = cyc;
         end
      end
   end

   // Serve one fetch at addr with 'waits' not-ready cycles, then answer the EXEC cycle with ps/h.
   task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input int waits,
                        input logic [1:0] ps, input logic h, input int gap);
      sb.push_back('{addr, word, gap});
      for (int i = 0; i <= waits; i++) begin
         imem_ready = (i == waits);
         imem_rdata = (i == waits) ? word : 32'hDEAD_BEEF;
         pcsrc      = 2'd2;   // ignored outside EXEC
         halt       = 1'b1;
         #1;
         chk("fetch_req", 32'(imem_req), 32'd1);
         chk("fetch_addr", imem_addr, addr);
         chk("fetch_no_stb", 32'(exec_stb), 32'd0);
         @(negedge clk);
      end
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      pcsrc      = ps;
      halt       = h;
      @(negedge clk);
      pcsrc = 2'd0;
      halt  = 1'b0;
   endtask

   task automatic do_reset();
      imem_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_req_low", 32'(imem_req), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_pc", pc, 32'h0000_0000);
      chk("rst_instr", instr, 32'h0);
      chk("rst_stb", 32'(exec_stb), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd1);
   endtask

   initial begin
      rst = 1'b1; pcsrc = 2'd0; halt = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
      @(negedge clk);
      @(negedge clk);
      do_reset();

      // Zero-wait sequential stream, then branches back/forward
      fetch(32'h0000_0000, 32'h2108_0001, 0, 2'd0, 1'b0, 0);
      fetch(32'h0000_0004, 32'h0009_5140, 0, 2'd0, 1'b0, 2);
      fetch(32'h0000_0008, 32'h8D2A_0004, 0, 2'd0, 1'b0, 2);
      fetch(32'h0000_000C, 32'h0149_5820, 0, 2'd0, 1'b0, 2);
      fetch(32'h0000_0010, 32'h1000_FFFF, 0, 2'd1, 1'b0, 2);
      fetch(32'h0000_0010, 32'h1000_0003, 0, 2'd1, 1'b0, 2);
      // Jump to top of region 0, walk across the 0x1000_0000 boundary, branch up
      fetch(32'h0000_0020, 32'h0BFF_FFFE, 0, 2'd2, 1'b0, 2);
      fetch(32'h0FFF_FFF8, 32'h0000_0000, 2, 2'd0, 1'b0, 4);
      fetch(32'h0FFF_FFFC, 32'h1000_0010, 0, 2'd1, 1'b0, 2);
      fetch(32'h1000_0040, 32'h0800_0010, 0, 2'd2, 1'b0, 2);
      fetch(32'h1000_0040, 32'h0800_0010, 0, 2'd3, 1'b0, 2);
      fetch(32'h1000_0044, 32'h0000_0000, 0, 2'd0, 1'b0, 2);

      // Wait states after reset
      do_reset();
      fetch(32'h0000_0000, 32'h2009_0005, 3, 2'd0, 1'b0, 0);
      fetch(32'h0000_0004, 32'h0000_0000, 0, 2'd0, 1'b0, 2);

      // Halt at 0x8 and hold with junk inputs
      fetch(32'h0000_0008, 32'hFC00_0000, 0, 2'd0, 1'b1, 2);
      for (int i = 0; i < 20; i++) begin
         imem_ready = 1'b1; imem_rdata = 32'h1234_5678; pcsrc = 2'd1; halt = 1'b0;
         #1;
         chk("halt_halted", 32'(halted), 32'd1);
         chk("halt_req", 32'(imem_req), 32'd0);
         chk("halt_pc", pc, 32'h0000_0008);
         chk("halt_instr", instr, 32'hFC00_0000);
         @(negedge clk);
      end
      pcsrc = 2'd0;
      do_reset();
      fetch(32'h0000_0000, 32'h2108_0001, 0, 2'd0, 1'b0, 0);

      // Reset while waiting in FETCH at 0x4
      imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("midwait_addr", imem_addr, 32'h0000_0004);
      do_reset();
      fetch(32'h0000_0000, 32'h0123_4567, 0, 2'd0, 1'b0, 0);

`ifdef IFETCH_TIMEOUT_EN
      imem_ready = 1'b0;
      repeat (14) @(negedge clk);
      #1;
      chk("to_fault_early", 32'(fault), 32'd0);
      @(negedge clk);
      #1;
      chk("to_fault", 32'(fault), 32'd1);
      chk("to_halted", 32'(halted), 32'd1);
      chk("to_pc", pc, 32'h0000_0004);
      repeat (3) @(negedge clk);
      #1;
      chk("to_sticky", 32'(fault), 32'd1);
      do_reset();
`endif

      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
